ysyx_25060173_ifu: RTL and testbench

Instruction fetch unit placed directly upstream of the single-cycle execute core. Holds the PC, issues one word fetch at a time to instruction memory over a valid/ready request channel, and captures the response. Presents the fetched instruction and its PC to the core over a valid/ready handshake. Accepts PC redirects (jumps and taken branches) from the core and discards stale in-flight responses.

---
 rtl/ysyx_25060173_ifu.sv | 154 +++++++++++++++
 tb/tb_ysyx_25060173_ifu.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060173_ifu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_25060173_ifu
//  Purpose  : Instruction fetch unit. Holds the PC, issues one word fetch at
//             a time over a valid/ready request channel, captures the
//             response and presents instruction + PC to the execute core.
//             Core redirects replace the PC; stale responses are dropped.
//  Ports    : clk, reset (async, active-low)
//             imem_req_*  : fetch request channel (valid/ready/addr)
//             imem_resp_* : fetch response (valid/data/err)
//             inst_*      : instruction handshake towards the core
//             redirect_*  : PC change requested by the core
//             fetch_pc    : current PC register
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_25060173_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_req_addr, w_req_addr_next;
  logic [31:0] r_inst, w_inst_next;
  logic [31:0] r_inst_pc, w_inst_pc_next;
  logic        r_inst_fault, w_inst_fault_next;
  logic        r_kill, w_kill_next;
  logic        w_misaligned;

  // The request address is latched on entry to REQ and frozen until the
  // request is accepted, so alignment is judged on that registered copy.
  // This keeps a pending request alive even if a redirect to a misaligned
  // target lands while the memory is still stalling it.
  assign w_misaligned = (r_req_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_inst       <= 32'h0;
      r_inst_pc    <= 32'h0;
      r_inst_fault <= 1'b0;
      r_kill       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_req_addr   <= w_req_addr_next;
      r_inst       <= w_inst_next;
      r_inst_pc    <= w_inst_pc_next;
      r_inst_fault <= w_inst_fault_next;
      r_kill       <= w_kill_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = redirect_valid ? redirect_pc : r_pc;
    w_req_addr_next   = r_req_addr;
    w_inst_next       = r_inst;
    w_inst_pc_next    = r_inst_pc;
    w_inst_fault_next = r_inst_fault;
    w_kill_next       = r_kill;

    unique case (r_state)
      S_IDLE: begin
        w_state_next = S_REQ;
      end

      S_REQ: begin
        if (w_misaligned) begin
          // Fault is delivered without touching memory; nothing to kill.
          w_state_next      = S_HOLD;
          w_inst_next       = 32'h0;
          w_inst_fault_next = 1'b1;
          w_inst_pc_next    = r_pc;
        end else begin
          if (redirect_valid) begin
            w_kill_next = 1'b1;
          end
          if (imem_req_ready) begin
            w_state_next = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (imem_resp_valid) begin
          if (r_kill || redirect_valid) begin
            w_kill_next  = 1'b0;
            w_state_next = S_REQ;
          end else begin
            w_inst_next       = imem_resp_err ? 32'h0 : imem_resp_data;
            w_inst_fault_next = imem_resp_err;
            w_inst_pc_next    = r_pc;
            w_state_next      = S_HOLD;
          end
        end else if (redirect_valid) begin
          w_kill_next = 1'b1;
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          w_state_next = S_REQ;
        end else if (inst_ready) begin
          w_pc_next    = r_pc + 32'd4;
          w_state_next = S_REQ;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if ((w_state_next == S_REQ) && (r_state != S_REQ)) begin
      w_req_addr_next = w_pc_next;
    end
  end

  assign imem_req_valid = (r_state == S_REQ) && !w_misaligned;
  assign imem_req_addr  = r_req_addr;
  assign inst_valid     = (r_state == S_HOLD);
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign inst_fault     = r_inst_fault;
  assign fetch_pc       = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25060173_ifu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ysyx_25060173_ifu
//  Purpose  : Self-checking bench for the instruction fetch unit: directed
//             scenarios followed by a randomized run against a
//             transaction-level model (next expected PC per delivery).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25060173_ifu;

  localparam logic [31:0] C_RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        imem_resp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] fetch_pc;

  int checks = 0;
  int errors = 0;

  // memory model controls
  bit          mem_fixed_en = 1'b0;
  logic [31:0] mem_fixed = 32'h0;
  bit          mem_err_force = 1'b0;
  bit          mem_err_rand = 1'b0;
  bit          mem_rand_ready = 1'b0;
  int          mem_lat = 1;
  int          accept_cnt = 0;

  // memory model state
  bit          m_pend = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr = 32'h0;
  bit          m_prev_stall = 1'b0;
  logic [31:0] m_prev_addr = 32'h0;
  logic [31:0] m_h;

  ysyx_25060173_ifu #(.RESET_PC(C_RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_pc       (fetch_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hashw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Instruction memory: one outstanding request, response mem_lat cycles
  // after acceptance (random 1..3 when mem_lat == 0).
  always @(negedge clk) begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    imem_resp_err   = 1'b0;
    if (!reset) begin
      m_pend         = 1'b0;
      m_prev_stall   = 1'b0;
      imem_req_ready = 1'b0;
    end else begin
      if (m_pend) begin
        if (m_cnt <= 1) begin
          m_h             = hashw(m_addr);
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_fixed_en ? mem_fixed : m_h;
          imem_resp_err   = mem_err_force || (mem_err_rand && (m_h[31:29] == 3'b000));
          m_pend          = 1'b0;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
      if (m_prev_stall) begin
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== m_prev_addr) begin
          errors++;
          $display("FAIL req_stable: valid=%b addr=%h, required valid=1 addr=%h",
                   imem_req_valid, imem_req_addr, m_prev_addr);
        end
      end
      imem_req_ready = mem_rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      m_prev_stall   = imem_req_valid && !imem_req_ready;
      m_prev_addr    = imem_req_addr;
      if (imem_req_valid && imem_req_ready) begin
        checks++;
        if (m_pend || imem_req_addr[1:0] != 2'b00) begin
          errors++;
          $display("FAIL req_accept: pending=%b addr=%h, required no pending and aligned addr",
                   m_pend, imem_req_addr);
        end
        accept_cnt++;
        m_pend = 1'b1;
        m_addr = imem_req_addr;
        m_cnt  = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== C_RESET_PC || fetch_pc !== C_RESET_PC) begin
      errors++;
      $display("FAIL reset_req: valid=%b addr=%h pc=%h, required 0/%h/%h",
               imem_req_valid, imem_req_addr, fetch_pc, C_RESET_PC, C_RESET_PC);
    end
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || inst_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_inst: valid=%b inst=%h pc=%h fault=%b, required all 0",
               inst_valid, inst, inst_pc, inst_fault);
    end
  endtask

  task automatic test_first_fetch();
    mem_fixed_en = 1'b1;
    mem_fixed    = 32'h0010_0093;
    mem_lat      = 1;
    @(negedge clk);
    reset = 1'b1;                 // cycle 0 (IDLE) follows
    @(negedge clk);               // cycle 1
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
      errors++;
      $display("FAIL first_req: valid=%b addr=%h, required 1/80000000", imem_req_valid, imem_req_addr);
    end
    @(negedge clk);               // cycle 2
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_early: inst_valid=%b in cycle 2, required 0", inst_valid);
    end
    @(negedge clk);               // cycle 3
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0000 || inst !== 32'h0010_0093 || inst_fault !== 1'b0) begin
      errors++;
      $display("FAIL first_inst: valid=%b pc=%h inst=%h fault=%b, required 1/80000000/00100093/0",
               inst_valid, inst_pc, inst, inst_fault);
    end
    mem_fixed_en = 1'b0;
    inst_ready   = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004 || fetch_pc !== 32'h8000_0004) begin
      errors++;
      $display("FAIL next_req: valid=%b addr=%h pc=%h, required 1/80000004/80000004",
               imem_req_valid, imem_req_addr, fetch_pc);
    end
  endtask

  task automatic test_backpressure();
    int acc0;
    for (int i = 0; i < 10 && !inst_valid; i++) @(negedge clk);
    acc0 = accept_cnt;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0004 || inst !== hashw(32'h8000_0004) ||
          imem_req_valid !== 1'b0 || accept_cnt != acc0) begin
        errors++;
        $display("FAIL backpressure: valid=%b pc=%h inst=%h reqv=%b acc=%0d, required 1/80000004/%h/0/%0d",
                 inst_valid, inst_pc, inst, imem_req_valid, accept_cnt, hashw(32'h8000_0004), acc0);
      end
      @(negedge clk);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0008) begin
      errors++;
      $display("FAIL bp_release: valid=%b reqv=%b addr=%h, required 0/1/80000008",
               inst_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_wait();
    bit seen;
    mem_fixed_en = 1'b1;
    mem_fixed    = 32'hDEAD_BEEF;
    @(negedge clk);               // WAIT: stale response present now
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    mem_fixed_en   = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
      errors++;
      $display("FAIL redir_wait_req: valid=%b reqv=%b addr=%h, required 0/1/80000100",
               inst_valid, imem_req_valid, imem_req_addr);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !inst_valid; i++) begin
      if (inst == 32'hDEAD_BEEF) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0100 || inst !== hashw(32'h8000_0100) || seen) begin
      errors++;
      $display("FAIL redir_wait_inst: valid=%b pc=%h inst=%h stale=%b, required 1/80000100/%h/0",
               inst_valid, inst_pc, inst, seen, hashw(32'h8000_0100));
    end
  endtask

  task automatic test_redirect_handshake();
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    @(negedge clk);
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin
      errors++;
      $display("FAIL redir_hs: reqv=%b addr=%h, required 1/80000200", imem_req_valid, imem_req_addr);
    end
    for (int i = 0; i < 10 && !inst_valid; i++) @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0200) begin
      errors++;
      $display("FAIL redir_hs_inst: valid=%b pc=%h, required 1/80000200", inst_valid, inst_pc);
    end
  endtask

  task automatic test_error();
    mem_err_force = 1'b1;
    inst_ready    = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    for (int i = 0; i < 10 && !inst_valid; i++) @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_fault !== 1'b1 || inst !== 32'h0 || inst_pc !== 32'h8000_0204) begin
      errors++;
      $display("FAIL err_inst: valid=%b fault=%b inst=%h pc=%h, required 1/1/0/80000204",
               inst_valid, inst_fault, inst, inst_pc);
    end
    mem_err_force = 1'b0;
    inst_ready    = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0208) begin
      errors++;
      $display("FAIL err_next: reqv=%b addr=%h, required 1/80000208", imem_req_valid, imem_req_addr);
    end
    for (int i = 0; i < 10 && !inst_valid; i++) @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_fault !== 1'b0 || inst_pc !== 32'h8000_0208 || inst !== hashw(32'h8000_0208)) begin
      errors++;
      $display("FAIL err_recover: valid=%b fault=%b pc=%h inst=%h, required 1/0/80000208/%h",
               inst_valid, inst_fault, inst_pc, inst, hashw(32'h8000_0208));
    end
  endtask

  task automatic test_misaligned_and_reset();
    int acc0;
    acc0           = accept_cnt;
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    @(negedge clk);
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b0 || fetch_pc !== 32'h8000_0102) begin
      errors++;
      $display("FAIL misal_req: reqv=%b pc=%h, required 0/80000102", imem_req_valid, fetch_pc);
    end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_fault !== 1'b1 || inst !== 32'h0 ||
        inst_pc !== 32'h8000_0102 || accept_cnt != acc0) begin
      errors++;
      $display("FAIL misal_inst: valid=%b fault=%b inst=%h pc=%h acc=%0d, required 1/1/0/80000102/%0d",
               inst_valid, inst_fault, inst, inst_pc, accept_cnt, acc0);
    end
    mem_lat        = 3;
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    @(negedge clk);
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0300) begin
      errors++;
      $display("FAIL misal_exit: reqv=%b addr=%h, required 1/80000300", imem_req_valid, imem_req_addr);
    end
    @(negedge clk);               // WAIT, response still outstanding
    #2 reset = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== C_RESET_PC || fetch_pc !== C_RESET_PC ||
        inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || inst_fault !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: reqv=%b addr=%h pc=%h iv=%b inst=%h ipc=%h fault=%b, required reset values",
               imem_req_valid, imem_req_addr, fetch_pc, inst_valid, inst, inst_pc, inst_fault);
    end
    mem_lat = 1;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, exp_inst, h, tgt;
    logic        exp_fault;
    bit          hs;
    int          idle, delivered;
    exp_pc       = C_RESET_PC;
    idle         = 0;
    delivered    = 0;
    mem_lat      = 0;
    mem_rand_ready = 1'b1;
    mem_err_rand = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      inst_ready     = 1'($urandom_range(0, 1));
      hs             = inst_valid && inst_ready;
      if (hs) begin
        h         = hashw(exp_pc);
        exp_fault = (exp_pc[1:0] != 2'b00) || (h[31:29] == 3'b000);
        exp_inst  = exp_fault ? 32'h0 : h;
        checks++;
        if (inst_pc !== exp_pc || inst !== exp_inst || inst_fault !== exp_fault) begin
          errors++;
          $display("FAIL rand_deliver: pc=%h inst=%h fault=%b, required %h/%h/%b",
                   inst_pc, inst, inst_fault, exp_pc, exp_inst, exp_fault);
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
        idle = 0;
      end else begin
        idle++;
      end
      // Mid-flight redirects only while the model PC is aligned, so the
      // misaligned shortcut is never raced by a redirect.
      if ((hs && $urandom_range(0, 3) == 0) ||
          (exp_pc[1:0] == 2'b00 && $urandom_range(0, 19) == 0) ||
          (hs && exp_pc[1:0] != 2'b00 && $urandom_range(0, 1) == 0)) begin
        tgt = 32'h8000_0000 | (32'($urandom_range(0, 1023)) << 2);
        if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFF4;
        if ($urandom_range(0, 7) == 0 && exp_pc[1:0] == 2'b00) tgt = tgt | 32'h2;
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        exp_pc         = tgt;
      end
      if (idle > 80) begin
        errors++;
        $display("FAIL rand_timeout: no delivery for %0d cycles, required progress", idle);
        break;
      end
    end
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    checks++;
    if (delivered < 100) begin
      errors++;
      $display("FAIL rand_throughput: delivered %0d, required at least 100", delivered);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_handshake();
    test_error();
    test_misaligned_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
